// File: rtl/sft_chain.sv
// sft_chain: driver for a daisy chain of NBYTE 74HC595-style shift registers.
// Takes a command (master reset, shift, storage latch, output enable) over a
// valid/ready handshake and generates SHCP/DS/STCP/MR_n/OE_n with a
// programmable half-period. All pin outputs come straight from flops.
// Optional feature macro: SFT_CHAIN_AUTO_LATCH_EN. When defined, a shift
// command finishes with an automatic storage latch before done.
module sft_chain #(
  parameter int NBYTE     = 2,
  parameter int HALF      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  output logic               rdy,
  input  logic [1:0]         cmd,
  input  logic               cmd_oen,
  input  logic [8*NBYTE-1:0] din,
  output logic               busy,
  output logic               done,
  output logic               sft_shcp,
  output logic               sft_ds,
  output logic               sft_stcp,
  output logic               sft_mr_n,
  output logic               sft_oe_n
);

  localparam int DW = 8 * NBYTE;
  localparam int CW = $clog2(DW + 1);
  localparam logic [7:0]    PH_LAST  = 8'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    MR,
    SH_LO,
    SH_HI,
    ST_HI,
    ST_LO
  } state_t;

  state_t        state, state_n;
  logic [7:0]    ph, ph_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] data, data_n, data_sh;
  logic          shcp, shcp_n;
  logic          ds, ds_n;
  logic          stcp, stcp_n;
  logic          mr_n, mr_n_n;
  logic          oe_n, oe_n_n;
  logic          done_r, done_n;
  logic          ph_last;

  // Bit that sits at the output end of the data register for the chosen order.
  function automatic logic head(input logic [DW-1:0] v);
    return (MSB_FIRST != 0) ? v[DW-1] : v[0];
  endfunction

  assign ph_last  = (ph == PH_LAST);
  assign data_sh  = (MSB_FIRST != 0) ? {data[DW-2:0], 1'b0} : {1'b0, data[DW-1:1]};

  assign rdy      = (state == IDLE);
  assign busy     = ~rdy;
  assign done     = done_r;
  assign sft_shcp = shcp;
  assign sft_ds   = ds;
  assign sft_stcp = stcp;
  assign sft_mr_n = mr_n;
  assign sft_oe_n = oe_n;

  // Register every piece of state, including all pin outputs, on clk; rst clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ph     <= '0;
      cnt    <= '0;
      data   <= '0;
      shcp   <= 1'b0;
      ds     <= 1'b0;
      stcp   <= 1'b0;
      mr_n   <= 1'b1;
      oe_n   <= 1'b1;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      cnt    <= cnt_n;
      data   <= data_n;
      shcp   <= shcp_n;
      ds     <= ds_n;
      stcp   <= stcp_n;
      mr_n   <= mr_n_n;
      oe_n   <= oe_n_n;
      done_r <= done_n;
    end
  end

  // Next-state and next-output logic; pins hold their value unless a phase boundary changes them.
  always_comb begin
    state_n = state;
    ph_n    = ph;
    cnt_n   = cnt;
    data_n  = data;
    shcp_n  = shcp;
    ds_n    = ds;
    stcp_n  = stcp;
    mr_n_n  = mr_n;
    oe_n_n  = oe_n;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (vld) begin
          case (cmd)
            2'b00: begin
              mr_n_n  = 1'b0;
              ph_n    = '0;
              cnt_n   = '0;
              state_n = MR;
            end
            2'b01: begin
              data_n  = din;
              cnt_n   = '0;
              ph_n    = '0;
              shcp_n  = 1'b0;
              ds_n    = head(din);
              state_n = SH_LO;
            end
            2'b10: begin
              stcp_n  = 1'b1;
              ph_n    = '0;
              state_n = ST_HI;
            end
            default: begin
              oe_n_n  = cmd_oen;
              done_n  = 1'b1;
            end
          endcase
        end
      end

      // The reset pulse lasts two half-periods; cnt marks which half we are in.
      MR: begin
        if (ph_last) begin
          ph_n = '0;
          if (cnt == CW'(1)) begin
            cnt_n   = '0;
            mr_n_n  = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = CW'(1);
          end
        end else begin
          ph_n = ph + 8'd1;
        end
      end

      SH_LO: begin
        if (ph_last) begin
          ph_n    = '0;
          shcp_n  = 1'b1;
          state_n = SH_HI;
        end else begin
          ph_n = ph + 8'd1;
        end
      end

      SH_HI: begin
        if (ph_last) begin
          ph_n   = '0;
          shcp_n = 1'b0;
          data_n = data_sh;
          cnt_n  = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
`ifdef SFT_CHAIN_AUTO_LATCH_EN
            stcp_n  = 1'b1;
            state_n = ST_HI;
`else
            done_n  = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            ds_n    = head(data_sh);
            state_n = SH_LO;
          end
        end else begin
          ph_n = ph + 8'd1;
        end
      end

      ST_HI: begin
        if (ph_last) begin
          ph_n    = '0;
          stcp_n  = 1'b0;
          state_n = ST_LO;
        end else begin
          ph_n = ph + 8'd1;
        end
      end

      ST_LO: begin
        if (ph_last) begin
          ph_n    = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          ph_n = ph + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sft_chain.sv
// tb_sft_chain: directed bench for sft_chain. Three instances cover the
// default build (NBYTE=2, HALF=4), MSB-first order, and a one-byte HALF=2
// chain whose expected shift latency depends on SFT_CHAIN_AUTO_LATCH_EN.
module tb_sft_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_a, vld_b, vld_c;
  logic [1:0]  cmd;
  logic        cmd_oen;
  logic [15:0] din;

  logic a_rdy, a_busy, a_done, a_shcp, a_ds, a_stcp, a_mr_n, a_oe_n;
  logic b_rdy, b_busy, b_done, b_shcp, b_ds, b_stcp, b_mr_n, b_oe_n;
  logic c_rdy, c_busy, c_done, c_shcp, c_ds, c_stcp, c_mr_n, c_oe_n;

  int   sel;
  logic o_done, o_shcp, o_ds, o_stcp, o_mr_n;

  int checks   = 0;
  int failures = 0;

  logic exp_lsb [16] = '{0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1};

  sft_chain #(.NBYTE(2), .HALF(4), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .vld(vld_a), .rdy(a_rdy), .cmd(cmd), .cmd_oen(cmd_oen),
    .din(din), .busy(a_busy), .done(a_done), .sft_shcp(a_shcp), .sft_ds(a_ds),
    .sft_stcp(a_stcp), .sft_mr_n(a_mr_n), .sft_oe_n(a_oe_n));

  sft_chain #(.NBYTE(2), .HALF(4), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .vld(vld_b), .rdy(b_rdy), .cmd(cmd), .cmd_oen(cmd_oen),
    .din(din), .busy(b_busy), .done(b_done), .sft_shcp(b_shcp), .sft_ds(b_ds),
    .sft_stcp(b_stcp), .sft_mr_n(b_mr_n), .sft_oe_n(b_oe_n));

  sft_chain #(.NBYTE(1), .HALF(2), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .vld(vld_c), .rdy(c_rdy), .cmd(cmd), .cmd_oen(cmd_oen),
    .din(din[7:0]), .busy(c_busy), .done(c_done), .sft_shcp(c_shcp), .sft_ds(c_ds),
    .sft_stcp(c_stcp), .sft_mr_n(c_mr_n), .sft_oe_n(c_oe_n));

  always #5 clk = ~clk;

  // Route the selected instance's pins to the shared observation signals.
  always_comb begin
    o_done = a_done; o_shcp = a_shcp; o_ds = a_ds; o_stcp = a_stcp; o_mr_n = a_mr_n;
    if (sel == 1) begin
      o_done = b_done; o_shcp = b_shcp; o_ds = b_ds; o_stcp = b_stcp; o_mr_n = b_mr_n;
    end else if (sel == 2) begin
      o_done = c_done; o_shcp = c_shcp; o_ds = c_ds; o_stcp = c_stcp; o_mr_n = c_mr_n;
    end
  end

  task automatic issue(input int s, input logic [1:0] c, input logic [15:0] d, input logic oen);
    @(negedge clk);
    sel = s; cmd = c; din = d; cmd_oen = oen;
    vld_a = (s == 0); vld_b = (s == 1); vld_c = (s == 2);
    @(posedge clk);
    #1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
  endtask

  task automatic capture(input int budget, input int gap, output int lat, output int nrise,
                         output logic [31:0] bits, output int first, output int badgap,
                         output int stcp_hi, output int mr_lo);
    int   last_rise;
    logic prev;
    lat = -1; nrise = 0; bits = '0; first = -1; badgap = 0;
    stcp_hi = 0; mr_lo = 0; last_rise = -1; prev = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_shcp && !prev) begin
        if (nrise < 32) bits[nrise] = o_ds;
        if (nrise == 0) first = k;
        else if (k - last_rise != gap) badgap++;
        last_rise = k;
        nrise++;
      end
      prev = o_shcp;
      if (o_stcp) stcp_hi++;
      if (!o_mr_n) mr_lo++;
      if (o_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen_done;
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    cmd = 2'b00; din = '0; cmd_oen = 1'b1; sel = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rdy, a_busy, a_done, a_shcp, a_ds, a_stcp, a_mr_n, a_oe_n} !== 8'b1000_0011) begin
      failures++;
      $display("[TB] FAIL reset_state: got %b expected 10000011",
               {a_rdy, a_busy, a_done, a_shcp, a_ds, a_stcp, a_mr_n, a_oe_n});
    end
    rst = 1'b0;
    issue(0, 2'b01, 16'hA53C, 1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if ({a_busy, a_shcp, a_ds} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL mid_shift_before_reset: busy/shcp/ds got %b expected 111",
               {a_busy, a_shcp, a_ds});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_rdy, a_busy, a_done, a_shcp, a_ds, a_stcp, a_mr_n, a_oe_n} !== 8'b1000_0011) begin
      failures++;
      $display("[TB] FAIL async_reset_mid_shift: got %b expected 10000011",
               {a_rdy, a_busy, a_done, a_shcp, a_ds, a_stcp, a_mr_n, a_oe_n});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_done || !a_rdy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("[TB] FAIL after_reset_idle: cycles with done or !rdy got %0d expected 0", seen_done);
    end
  endtask

  task automatic test_shift_lsb();
    int lat, nrise, first, badgap, sh, ml;
    logic [31:0] bits;
    issue(0, 2'b01, 16'hA53C, 1'b1);
    capture(300, 8, lat, nrise, bits, first, badgap, sh, ml);
    checks++;
    if (lat !== 128) begin failures++; $display("[TB] FAIL shift_latency: got %0d expected 128", lat); end
    checks++;
    if (nrise !== 16) begin failures++; $display("[TB] FAIL shift_rises: got %0d expected 16", nrise); end
    checks++;
    if (first !== 4 || badgap !== 0) begin
      failures++;
      $display("[TB] FAIL shift_spacing: first rise %0d bad gaps %0d expected 4 and 0", first, badgap);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bits[i] !== exp_lsb[i]) begin
        failures++;
        $display("[TB] FAIL shift_ds_rise%0d: got %b expected %b", i + 1, bits[i], exp_lsb[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_done, a_shcp, a_ds, a_rdy} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL shift_after_done: done/shcp/ds/rdy got %b expected 0011",
               {a_done, a_shcp, a_ds, a_rdy});
    end
  endtask

  task automatic test_shift_msb();
    int lat, nrise, first, badgap, sh, ml;
    logic [31:0] bits;
    issue(1, 2'b01, 16'h8001, 1'b1);
    capture(300, 8, lat, nrise, bits, first, badgap, sh, ml);
    checks++;
    if (nrise !== 16 || lat !== 128) begin
      failures++;
      $display("[TB] FAIL msb_shape: rises %0d latency %0d expected 16 and 128", nrise, lat);
    end
    checks++;
    if (bits[15:0] !== 16'h8001) begin
      failures++;
      $display("[TB] FAIL msb_ds_pattern: got %h expected 8001", bits[15:0]);
    end
  endtask

  task automatic test_latch_oe();
    int lat, nrise, first, badgap, sh, ml;
    logic [31:0] bits;
    issue(0, 2'b10, 16'h0000, 1'b1);
    capture(40, 8, lat, nrise, bits, first, badgap, sh, ml);
    checks++;
    if (sh !== 4 || lat !== 8 || nrise !== 0) begin
      failures++;
      $display("[TB] FAIL latch: stcp high %0d latency %0d rises %0d expected 4, 8, 0", sh, lat, nrise);
    end
    issue(0, 2'b11, 16'h0000, 1'b0);
    @(negedge clk);
    checks++;
    if ({a_oe_n, a_done} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL oe_cmd: oe_n/done got %b expected 01", {a_oe_n, a_done});
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin failures++; $display("[TB] FAIL oe_done_width: got %b expected 0", a_done); end
    issue(0, 2'b00, 16'h0000, 1'b1);
    capture(40, 8, lat, nrise, bits, first, badgap, sh, ml);
    checks++;
    if (ml !== 8 || lat !== 8) begin
      failures++;
      $display("[TB] FAIL master_reset: mr_n low %0d latency %0d expected 8 and 8", ml, lat);
    end
    checks++;
    if ({a_mr_n, a_oe_n} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mr_keeps_oe: mr_n/oe_n got %b expected 10", {a_mr_n, a_oe_n});
    end
  endtask

  task automatic test_back_to_back();
    int lat, nrise, first, badgap, sh, ml;
    logic [31:0] bits;
    @(negedge clk);
    sel = 0; cmd = 2'b11; cmd_oen = 1'b1; din = 16'h0000; vld_a = 1'b1;
    @(posedge clk);
    #1;
    cmd = 2'b01; din = 16'h00FF;
    @(negedge clk);
    checks++;
    if ({a_done, a_rdy, a_oe_n} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL b2b_done_cycle: done/rdy/oe_n got %b expected 111", {a_done, a_rdy, a_oe_n});
    end
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    fork
      capture(300, 8, lat, nrise, bits, first, badgap, sh, ml);
      begin
        repeat (20) @(negedge clk);
        vld_a = 1'b1; cmd = 2'b10; din = 16'hFFFF;
        repeat (3) @(negedge clk);
        vld_a = 1'b0;
      end
    join
    checks++;
    if (lat !== 128 || nrise !== 16) begin
      failures++;
      $display("[TB] FAIL b2b_shift: latency %0d rises %0d expected 128 and 16", lat, nrise);
    end
    checks++;
    if (bits[15:0] !== 16'h00FF || sh !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_ignore_busy: ds %h stcp high %0d expected 00ff and 0", bits[15:0], sh);
    end
  endtask

  task automatic test_auto_latch();
    int lat, nrise, first, badgap, sh, ml;
    logic [31:0] bits;
    int exp_lat, exp_sh;
`ifdef SFT_CHAIN_AUTO_LATCH_EN
    exp_lat = 36; exp_sh = 2;
`else
    exp_lat = 32; exp_sh = 0;
`endif
    issue(2, 2'b01, 16'h00A5, 1'b1);
    capture(200, 4, lat, nrise, bits, first, badgap, sh, ml);
    checks++;
    if (nrise !== 8 || badgap !== 0 || bits[7:0] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL small_chain_shift: rises %0d bad gaps %0d ds %h expected 8, 0, a5",
               nrise, badgap, bits[7:0]);
    end
    checks++;
    if (lat !== exp_lat || sh !== exp_sh) begin
      failures++;
      $display("[TB] FAIL auto_latch: latency %0d stcp high %0d expected %0d and %0d",
               lat, sh, exp_lat, exp_sh);
    end
  endtask

  initial begin
    test_reset();
    test_shift_lsb();
    test_shift_msb();
    test_latch_oe();
    test_back_to_back();
    test_auto_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
